// File: rtl/index_sequencer_pkg.sv
// Shared types and constants for the index sequencer.
// Bounce support is built only when INDEX_SEQ_BOUNCE_EN is defined.
package index_sequencer_pkg;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    localparam int unsigned IDX_W = 3;

    localparam logic [IDX_W-1:0] IDX_MIN = 3'd0;
    localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;

    function automatic logic [IDX_W-1:0] step_index(
        input logic [IDX_W-1:0] idx,
        input logic             up
    );
        logic [IDX_W-1:0] r;
        if (up) r = idx + 1'b1;
        else    r = idx - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/index_sequencer_prescaler.sv
// Prescaler that emits a terminal-count pulse every DIV enabled cycles.
// Part of index_sequencer (INDEX_SEQ_BOUNCE_EN does not affect this file).
module tick_prescaler #(
    parameter int unsigned DIV        = 50000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    input  logic En,
    output logic Tc
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(DIV - 1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic                  at_last;

    assign at_last = (cnt_q == LAST);

    // Held at zero when disabled; wraps to zero on the terminal count.
    always_comb begin
        cnt_d = '0;
        if (!Clear && En && !at_last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign Tc = En && !Clear && at_last;

endmodule

// File: rtl/index_sequencer.sv
// Stepping 3-bit index generator feeding a 3-to-8 decoder.
// Define INDEX_SEQ_BOUNCE_EN to build ping-pong mode and the up_q flag.
module index_sequencer
    import index_sequencer_pkg::*;
#(
    parameter int unsigned DIV        = 50000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Dir,
    input  logic             Bounce,
    input  logic             Step,
    input  logic             Load,
    input  logic [IDX_W-1:0] LoadVal,
    output logic [IDX_W-1:0] Index,
    output logic             Tick,
    output logic             Wrap,
    output logic             Active
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             step_q;
    logic             running;
    logic             clear;
    logic             tc;
    logic             adv;

    assign state_d = Run ? ST_RUNNING : ST_STOPPED;
    assign running = (state_q == ST_RUNNING);
    assign clear   = (state_d != state_q) || Load;

    tick_prescaler #(
        .DIV       (DIV),
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .Clk  (Clk),
        .Reset(Reset),
        .Clear(clear),
        .En   (running),
        .Tc   (tc)
    );

    assign adv = running ? tc : (Step && !step_q);

`ifdef INDEX_SEQ_BOUNCE_EN
    logic up_q, up_d;
    logic go_up;

    // At the ends the direction is forced, so a load onto an end still bounces.
    always_comb begin
        go_up = up_q;
        if (idx_q == IDX_MIN)      go_up = 1'b1;
        else if (idx_q == IDX_MAX) go_up = 1'b0;
    end
`else
    logic bounce_unused;
    assign bounce_unused = Bounce;
`endif

    always_comb begin
        idx_d  = idx_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
`ifdef INDEX_SEQ_BOUNCE_EN
        up_d   = up_q;
`endif
        if (Load) begin
            idx_d = LoadVal;
`ifdef INDEX_SEQ_BOUNCE_EN
            up_d  = 1'b1;
`endif
        end else if (adv) begin
            tick_d = 1'b1;
`ifdef INDEX_SEQ_BOUNCE_EN
            if (Bounce) begin
                idx_d  = step_index(idx_q, go_up);
                wrap_d = (idx_d == IDX_MAX) || (idx_d == IDX_MIN);
                if (idx_d == IDX_MAX) up_d = 1'b0;
                if (idx_d == IDX_MIN) up_d = 1'b1;
            end else begin
                idx_d  = step_index(idx_q, !Dir);
                wrap_d = Dir ? (idx_q == IDX_MIN) : (idx_q == IDX_MAX);
            end
`else
            idx_d  = step_index(idx_q, !Dir);
            wrap_d = Dir ? (idx_q == IDX_MIN) : (idx_q == IDX_MAX);
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_STOPPED;
            idx_q   <= IDX_MIN;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            step_q  <= Step;
        end
    end

`ifdef INDEX_SEQ_BOUNCE_EN
    always_ff @(posedge Clk) begin
        if (Reset) up_q <= 1'b1;
        else       up_q <= up_d;
    end
`endif

    assign Index  = idx_q;
    assign Tick   = tick_q;
    assign Wrap   = wrap_q;
    assign Active = running;

endmodule

// File: tb/tb_index_sequencer.sv
// Directed self-checking bench for index_sequencer (DIV=4 and DIV=1 copies).
module tb_index_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, Run, Dir, Bounce, Step, Load;
    logic [2:0] LoadVal;

    logic [2:0] idx4, idx1;
    logic       tick4, tick1, wrap4, wrap1, act4, act1;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    index_sequencer #(.DIV(4), .PRESCALE_W(4)) u4 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Dir(Dir), .Bounce(Bounce),
        .Step(Step), .Load(Load), .LoadVal(LoadVal),
        .Index(idx4), .Tick(tick4), .Wrap(wrap4), .Active(act4)
    );

    index_sequencer #(.DIV(1), .PRESCALE_W(4)) u1 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Dir(Dir), .Bounce(Bounce),
        .Step(Step), .Load(Load), .LoadVal(LoadVal),
        .Index(idx1), .Tick(tick1), .Wrap(wrap1), .Active(act1)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    initial begin
        logic [2:0] e;
        logic       w;
        Reset = 1'b0; Run = 1'b0; Dir = 1'b0; Bounce = 1'b0;
        Step = 1'b0; Load = 1'b0; LoadVal = 3'd0;

        do_reset();
        check("rst_index", idx4, 0);
        check("rst_tick", tick4, 0);
        check("rst_wrap", wrap4, 0);
        check("rst_active", act4, 0);

        // Up count, DIV=4
        Run = 1'b1;
        cyc();
        check("run_active", act4, 1);
        check("run_idx0", idx4, 0);
        for (int k = 1; k <= 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                cyc();
                check("up_notick", tick4, 0);
            end
            cyc();
            e = 3'(k % 8);
            check("up_index", idx4, e);
            check("up_tick", tick4, 1);
            check("up_wrap", wrap4, (k == 8) ? 1 : 0);
        end

        // Load coincident with terminal count
        repeat (3) cyc();
        Load = 1'b1; LoadVal = 3'd5;
        cyc();
        Load = 1'b0;
        check("load_index", idx4, 5);
        check("load_notick", tick4, 0);
        check("load_nowrap", wrap4, 0);
        for (int j = 0; j < 3; j++) begin
            cyc();
            check("load_hold", idx4, 5);
            check("load_hold_tick", tick4, 0);
        end
        cyc();
        check("load_next", idx4, 6);
        check("load_next_tick", tick4, 1);

        // Reset mid-run
        Load = 1'b1; LoadVal = 3'd3;
        cyc();
        Load = 1'b0;
        check("set3", idx4, 3);
        Reset = 1'b1; Run = 1'b0;
        cyc();
        Reset = 1'b0;
        check("mrst_index", idx4, 0);
        check("mrst_active", act4, 0);
        check("mrst_tick", tick4, 0);
        repeat (8) cyc();
        check("mrst_idle_index", idx4, 0);
        check("mrst_idle_active", act4, 0);

        // Single-step while stopped
        Step = 1'b1;
        cyc();
        check("step_first", idx4, 1);
        check("step_first_tick", tick4, 1);
        repeat (9) cyc();
        check("step_held", idx4, 1);
        check("step_held_tick", tick4, 0);
        Step = 1'b0; cyc();
        Step = 1'b1; cyc();
        check("step_2", idx4, 2);
        Step = 1'b0; cyc();
        Step = 1'b1; cyc();
        Step = 1'b0; cyc();
        check("step_3", idx4, 3);

        // Down count, DIV=1
        do_reset();
        Run = 1'b1; Dir = 1'b1;
        cyc();
        check("dn_idx0", idx1, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            e = 3'((8 - (k % 8)) % 8);
            check("dn_index", idx1, e);
            check("dn_tick", tick1, 1);
            check("dn_wrap", wrap1, (e == 3'd7) ? 1 : 0);
        end

        // Bounce, DIV=1
        Run = 1'b0; Dir = 1'b0;
        do_reset();
        Bounce = 1'b1; Run = 1'b1;
        cyc();
        for (int k = 1; k <= 17; k++) begin
            cyc();
`ifdef INDEX_SEQ_BOUNCE_EN
            if (k <= 7)       e = 3'(k);
            else if (k <= 14) e = 3'(14 - k);
            else              e = 3'(k - 14);
            w = (e == 3'd7) || (e == 3'd0);
`else
            e = 3'(k % 8);
            w = (e == 3'd0);
`endif
            check("bnc_index", idx1, e);
            check("bnc_wrap", wrap1, w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/index_sequencer.md
# index_sequencer

Sequential index generator that drives the 3-bit select input of the 3-to-8 decoder, producing a stepping one-hot pattern for LED chasers and digit-scan displays. A prescaler divides the system clock into advance events; the index counts up, down, or ping-pongs. It can also be single-stepped or loaded directly. It sits directly upstream of the decoder: `Index` connects to the decoder's `In`.

## Interface
- `DIV`, default 50000: clock cycles per advance while running. Legal range is 1 to 2^`PRESCALE_W`.
- `PRESCALE_W`, default 16: prescaler counter width.
- `Clk`, in, 1: system clock. All logic is on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Run`, in, 1: level. 1 = free-running advance.
- `Dir`, in, 1: 0 = up, 1 = down. Ignored in bounce mode.
- `Bounce`, in, 1: 1 = ping-pong mode (see Configuration).
- `Step`, in, 1: single-step request. Acts on its rising edge, and only while stopped.
- `Load`, in, 1: synchronous load strobe.
- `LoadVal`, in, 3: value placed on `Index` when `Load` is asserted.
- `Index`, out, 3: current index, sent to the decoder. Registered.
- `Tick`, out, 1: one-cycle pulse, high in the first cycle a new `Index` is visible. Registered.
- `Wrap`, out, 1: one-cycle pulse alongside `Tick` when the advance reaches or crosses an end. Registered.
- `Active`, out, 1: 1 while in state RUNNING.

## Operation
- States:
  - STOPPED: the reset state.
  - RUNNING.
- Transitions:
  - STOPPED → RUNNING when `Run`=1.
  - RUNNING → STOPPED when `Run`=0.
  - The prescaler is cleared to 0 on every state change and is held at 0 while STOPPED.
- Priority per cycle: `Reset` > `Load` > advance.
- Advance sources:
  - RUNNING: the prescaler reaches `DIV`-1; the prescaler then returns to 0.
  - STOPPED: `Step`=1 while the registered `Step_q`=0 (rising edge). Holding `Step` high gives exactly one advance. `Step` is ignored while RUNNING.
- Linear mode (`Bounce`=0):
  - Up: `Index` becomes `Index`+1 mod 8. `Wrap` fires on 7→0.
  - Down: `Index` becomes `Index`-1 mod 8. `Wrap` fires on 0→7.
- Bounce mode: an internal direction flag, `up_q`, starts at up.
  - Up: `Index`+1. Down: `Index`-1.
  - When `Index` reaches 7, the flag flips to down. When it reaches 0, the flag flips to up.
  - `Wrap` fires on the advance that lands on 7 or 0.
- `Load`:
  - `Index` takes `LoadVal` and the prescaler clears.
  - `up_q` is set to up. `Tick` and `Wrap` are not asserted.
  - The state is unchanged, and any coincident advance is discarded.
- `Dir` or `Bounce` changes take effect on the next advance.
- Reset values: `Index`=0, `Tick`=0, `Wrap`=0, `Active`=0, state STOPPED, prescaler 0, `up_q`=up, `Step_q`=0.

## Timing
- RUNNING advance:
  - Take the edge where `Run` is first sampled high as edge 0.
  - The first advance occurs at edge `DIV`, and then every `DIV` edges after that.
  - `DIV`=1 advances on every edge from edge 1.
- Step: the edge sampling `Step`=1 with `Step_q`=0 updates `Index`. `Tick` is high for the following cycle.
- `Active` follows the state register. It rises one cycle after `Run` is first sampled high.
- A `Run` drop mid-count cancels the pending advance with no partial tick. Restarting waits a full `DIV` cycles.
- `Reset` mid-operation: all registers take their reset values at that edge.

## Configuration
- `INDEX_SEQ_BOUNCE_EN` defined:
  - Bounce mode and `up_q` are built.
  - The `Bounce` input selects between ping-pong and linear operation.
- `INDEX_SEQ_BOUNCE_EN` undefined:
  - The `Bounce` port remains but is ignored.
  - Only linear up/down operation exists, and `up_q` is not built.

## Structure
- Shared package holds:
  - the STOPPED/RUNNING state encoding;
  - the index width (3);
  - the end constants `IDX_MIN`=0 and `IDX_MAX`=7.
- One sub-module, `tick_prescaler`:
  - parameters `DIV` and `PRESCALE_W`;
  - inputs `Clk`, `Reset`, and `Clear`;
  - input `En` (=RUNNING);
  - output `Tc` (terminal-count pulse).

## Test plan
- Reset, then `Run`=1, `Dir`=0, `DIV`=4 → `Index` steps 0→1→2…7→0 every 4 cycles. `Tick` pulses each time. `Wrap` pulses only on 7→0.
- `Run`=1, `Dir`=1, starting from 0, `DIV`=1 → `Index` 7,6,5… every cycle. `Wrap` pulses on 0→7.
- `Run`=0, hold `Step` high 10 cycles, then pulse `Step` twice → `Index` advances by exactly 3 in total. No advance occurs while `Step` is held.
- Bounce=1, `DIV`=1, with `INDEX_SEQ_BOUNCE_EN` defined → `Index` sequence 0,1…7,6…0,1. `Wrap` pulses on arrival at 7 and at 0.
- `Load`=1 with `LoadVal`=5, coincident with a prescaler terminal count while RUNNING → `Index`=5 with no `Tick`. The next advance to 6 comes `DIV` cycles later.
- Set `Index`=3 while running, then assert `Reset` for 1 cycle → next cycle: `Index`=0, `Active`=0, `Tick`=0, and no advance until `Run` is sampled high again.
